// File: rtl/conv_window_gen_3x3.sv
// Streaming 3x3 window generator: buffers two lines of a raster 8-bit pixel
// stream and emits one packed 72-bit window per valid (unpadded) position.
module conv_window_gen_3x3 #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [71:0] win_out,
  output logic        win_valid,
  input  logic        win_ready,
  output logic        frame_done
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  // lb1 holds row r-1, lb0 holds row r-2, both indexed by column
  logic [7:0] lb0_q [IMG_W];
  logic [7:0] lb1_q [IMG_W];

  // win_q[3*dr + dc]: dr=0 oldest row, dc=0 oldest column
  logic [7:0] win_q [9];
  logic [7:0] win_d [9];
  logic [71:0] win_pack;

  logic        accept;
  logic        col_last, row_last;
  logic        produce;
  logic        win_valid_q;
  logic [71:0] win_out_q;
  logic        last_q;

  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign col_last  = (col_q == ColW'(IMG_W - 1));
  assign row_last  = (row_q == RowW'(IMG_H - 1));
  assign produce   = accept && (row_q >= RowW'(2)) && (col_q >= ColW'(2));

  assign win_valid  = win_valid_q;
  assign win_out    = win_out_q;
  assign frame_done = win_valid_q && win_ready && last_q;

  // Raster position counters advance on every accepted pixel
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Counter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Shifted window: new right column uses line-buffer contents before this write
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[3*r]     = win_q[3*r+1];
      win_d[3*r + 1] = win_q[3*r+2];
    end
    win_d[2] = lb0_q[col_q];
    win_d[5] = lb1_q[col_q];
    win_d[8] = pix_in;
  end

  // Pack pixel k into bits [8k+7:8k]
  always_comb begin
    win_pack = '0;
    for (int k = 0; k < 9; k++) begin
      win_pack[8*k +: 8] = win_d[k];
    end
  end

  // Line buffers and window shift register; contents need no reset because
  // rows 0 and 1 refill them before any window is produced
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= pix_in;
      win_q        <= win_d;
    end
  end

  // Output register: a new window wins over a simultaneous downstream accept
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_q <= 1'b0;
      win_out_q   <= '0;
      last_q      <= 1'b0;
    end else if (produce) begin
      win_valid_q <= 1'b1;
      win_out_q   <= win_pack;
      last_q      <= row_last && col_last;
    end else if (win_valid_q && win_ready) begin
      win_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Directed bench for conv_window_gen_3x3 with a 4x4 image.
module tb_conv_window_gen_3x3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [71:0] win_out;
  logic        win_valid;
  logic        win_ready = 1'b1;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Reference state: expected windows in order, raster position, output valid
  logic [71:0] exp_q[$];
  bit          exp_last[$];
  int          mpos = 0;
  bit          m_valid = 1'b0;
  int          next_pix = 0;
  int          fd_count = 0;

  conv_window_gen_3x3 #(.IMG_W(4), .IMG_H(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .win_out   (win_out),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk72(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chkint(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_frame(input bit second);
    if (!second) begin
      exp_q.push_back(72'h0A0908060504020100);
      exp_q.push_back(72'h0B0A09070605030201);
      exp_q.push_back(72'h0E0D0C0A0908060504);
      exp_q.push_back(72'h0F0E0D0B0A09070605);
    end else begin
      exp_q.push_back(72'h1A1918161514121110);
      exp_q.push_back(72'h1B1A19171615131211);
      exp_q.push_back(72'h1E1D1C1A1918161514);
      exp_q.push_back(72'h1F1E1D1B1A19171615);
    end
    exp_last.push_back(1'b0);
    exp_last.push_back(1'b0);
    exp_last.push_back(1'b0);
    exp_last.push_back(1'b1);
  endtask

  // One clock: drive inputs on the falling edge, check just after, then
  // advance the reference to what the next rising edge should do
  task automatic step(input bit pv, input bit wr);
    bit prod;
    @(negedge clk);
    pix_valid = pv;
    pix_in    = 8'(next_pix);
    win_ready = wr;
    #1;
    chk1("pix_ready", pix_ready, !m_valid || wr);
    chk1("win_valid", win_valid, m_valid);
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        chk1("extra_window", win_valid, 1'b0);
      end else begin
        chk72("win_out", win_out, exp_q[0]);
        if (wr) begin
          chk1("frame_done", frame_done, exp_last[0]);
          if (frame_done) fd_count++;
          void'(exp_q.pop_front());
          void'(exp_last.pop_front());
        end else begin
          chk1("frame_done_stall", frame_done, 1'b0);
        end
      end
    end else begin
      chk1("frame_done_idle", frame_done, 1'b0);
    end
    prod = 1'b0;
    if (pv && (!m_valid || wr)) begin
      prod = (mpos / 4 >= 2) && (mpos % 4 >= 2);
      mpos = (mpos + 1) % 16;
      next_pix++;
    end
    if (prod) m_valid = 1'b1;
    else if (wr) m_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    pix_valid = 1'b0;
    win_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rst_win_valid", win_valid, 1'b0);
    chk72("rst_win_out", win_out, 72'h0);
    chk1("rst_frame_done", frame_done, 1'b0);
    chk1("rst_pix_ready", pix_ready, 1'b1);
    m_valid  = 1'b0;
    mpos     = 0;
    next_pix = 0;
    exp_q.delete();
    exp_last.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (m_valid || exp_q.size() != 0); i++) step(1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    do_reset();

    // Continuous stream, windows one cycle after pixels 10, 11, 14, 15
    push_frame(1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
    drain();
    chkint("s1_remaining", exp_q.size(), 0);

    // Downstream stall while the first window is presented
    next_pix = 0;
    push_frame(1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 20 && next_pix < 16; i++) step(1'b1, 1'b1);
    drain();
    chkint("s2_remaining", exp_q.size(), 0);
    chkint("s2_pixels", next_pix, 16);

    // Random input gaps and output stalls
    next_pix = 0;
    push_frame(1'b0);
    for (int i = 0; i < 400 && next_pix < 16; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    chkint("s3_pixels", next_pix, 16);
    drain();
    chkint("s3_remaining", exp_q.size(), 0);

    // Two back-to-back frames
    next_pix = 0;
    fd_count = 0;
    push_frame(1'b0);
    push_frame(1'b1);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1);
    drain();
    chkint("s4_remaining", exp_q.size(), 0);
    chkint("s4_frame_done_count", fd_count, 2);

    // Abort after pixel 9, then a clean frame
    next_pix = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    do_reset();
    push_frame(1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
    drain();
    chkint("s5_remaining", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
